// File: rtl/control_ingreso_teclado.sv
// Keypad entry controller: debounces scanned key codes, edits a BCD digit buffer
// and commits it over valid/ready on enter. Optional inactivity clear: CONTROL_INGRESO_TIMEOUT_EN.
module control_ingreso_teclado #(
   parameter int NDIG  = 4,
   parameter int DEB_N = 3,
   parameter int REL_N = 8,
   parameter int TMO   = 1000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [4:0]           digito,
   input  logic                 cambio_digito,
   input  logic                 enter_sync,
   input  logic                 out_ready,
   output logic                 out_valid,
   output logic [4*NDIG-1:0]    out_valor,
   output logic [2:0]           out_cant,
   output logic [4*NDIG-1:0]    disp_valor,
   output logic [2:0]           disp_cant,
   output logic                 tecla_pulso,
   output logic                 overflow
);

   localparam int QW = $clog2(REL_N + 1);
   localparam int DW = $clog2(DEB_N + 1);

   typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, COMMIT} state_t;

   state_t              state, state_nx;
   logic [QW-1:0]       q_cnt;
   logic [DW-1:0]       s_cnt, s_cnt_nx;
   logic [3:0]          cand, cand_nx;
   logic [4*NDIG-1:0]   buf_q, buf_nx, val_q;
   logic [2:0]          cnt_q, cnt_nx, ocnt_q;
   logic                ent_q;
   logic                sight, quiet_done, ent_edge, accept, commit, handshake;
   logic                puls_nx, ovf_nx, tmo_hit;

   assign sight      = cambio_digito && (digito <= 5'd15);
   assign quiet_done = (q_cnt == QW'(REL_N));
   assign ent_edge   = enter_sync && !ent_q;
   assign commit     = ent_edge && (state != COMMIT) && (cnt_q != 3'd0);
   assign handshake  = (state == COMMIT) && out_ready;

   // Consecutive quiet cycles; saturates so a long idle keeps reporting release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         q_cnt <= '0;
      else if (sight)
         q_cnt <= '0;
      else if (!quiet_done)
         q_cnt <= q_cnt + 1'b1;
   end

   always_comb begin
      state_nx = state;
      s_cnt_nx = s_cnt;
      cand_nx  = cand;
      accept   = 1'b0;
      case (state)
         IDLE: begin
            if (sight) begin
               cand_nx  = digito[3:0];
               s_cnt_nx = DW'(1);
               state_nx = DEBOUNCE;
            end
         end
         DEBOUNCE: begin
            if (sight) begin
               if (digito[3:0] == cand) begin
                  s_cnt_nx = s_cnt + 1'b1;
                  if (s_cnt_nx == DW'(DEB_N)) begin
                     accept   = 1'b1;
                     state_nx = HELD;
                  end
               end else begin
                  cand_nx  = digito[3:0];
                  s_cnt_nx = DW'(1);
               end
            end else if (quiet_done) begin
               state_nx = IDLE;
            end
         end
         HELD: begin
            if (quiet_done)
               state_nx = IDLE;
         end
         COMMIT: begin
            if (handshake)
               state_nx = HELD;
         end
         default: state_nx = IDLE;
      endcase
      // Enter overrides any key accepted in the same cycle.
      if (commit)
         state_nx = COMMIT;
   end

   always_comb begin
      buf_nx  = buf_q;
      cnt_nx  = cnt_q;
      puls_nx = 1'b0;
      ovf_nx  = 1'b0;
      if (handshake) begin
         buf_nx = '0;
         cnt_nx = 3'd0;
      end else if (accept && !commit) begin
         puls_nx = 1'b1;
         if (cand <= 4'd9) begin
            if (cnt_q < 3'(NDIG)) begin
               buf_nx = (4*NDIG)'({buf_q, cand});
               cnt_nx = cnt_q + 3'd1;
            end else begin
               ovf_nx = 1'b1;
            end
         end else if (cand == 4'hF) begin
            if (cnt_q != 3'd0) begin
               buf_nx = buf_q >> 4;
               cnt_nx = cnt_q - 3'd1;
            end
         end else if (cand == 4'hE) begin
            buf_nx = '0;
            cnt_nx = 3'd0;
         end
      end else if (tmo_hit) begin
         buf_nx = '0;
         cnt_nx = 3'd0;
      end
   end

`ifdef CONTROL_INGRESO_TIMEOUT_EN
   localparam int TW = $clog2(TMO + 1);
   logic [TW-1:0] tmo_cnt;
   logic          tmo_run;

   // Frozen in DEBOUNCE and COMMIT, restarted by any accepted key or enter edge.
   assign tmo_run = ((state == IDLE) || (state == HELD)) && (cnt_q != 3'd0);
   assign tmo_hit = tmo_run && (tmo_cnt == TW'(TMO));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         tmo_cnt <= '0;
      else if (accept || ent_edge || (cnt_q == 3'd0) || tmo_hit)
         tmo_cnt <= '0;
      else if (tmo_run)
         tmo_cnt <= tmo_cnt + 1'b1;
   end
`else
   assign tmo_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         s_cnt       <= '0;
         cand        <= 4'd0;
         buf_q       <= '0;
         cnt_q       <= 3'd0;
         ent_q       <= 1'b0;
         val_q       <= '0;
         ocnt_q      <= 3'd0;
         tecla_pulso <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         state       <= state_nx;
         s_cnt       <= s_cnt_nx;
         cand        <= cand_nx;
         buf_q       <= buf_nx;
         cnt_q       <= cnt_nx;
         ent_q       <= enter_sync;
         tecla_pulso <= puls_nx;
         overflow    <= ovf_nx;
         if (commit) begin
            val_q  <= buf_q;
            ocnt_q <= cnt_q;
         end
      end
   end

   // Valid is the COMMIT state itself, so async reset drops it at once.
   assign out_valid  = (state == COMMIT);
   assign out_valor  = val_q;
   assign out_cant   = ocnt_q;
   assign disp_valor = buf_q;
   assign disp_cant  = cnt_q;

endmodule

// File: tb/tb_control_ingreso_teclado.sv
// Directed bench for control_ingreso_teclado: table of key presses plus
// hand-written enter/handshake, bounce, coincidence and reset sequences.
module tb_control_ingreso_teclado;

   localparam int NDIG = 4;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic [4:0]          digito = 5'd16;
   logic                cambio_digito = 1'b0;
   logic                enter_sync = 1'b0;
   logic                out_ready = 1'b0;
   logic                out_valid;
   logic [4*NDIG-1:0]   out_valor;
   logic [2:0]          out_cant;
   logic [4*NDIG-1:0]   disp_valor;
   logic [2:0]          disp_cant;
   logic                tecla_pulso;
   logic                overflow;

   control_ingreso_teclado #(.NDIG(NDIG), .DEB_N(3), .REL_N(8), .TMO(1000)) dut (
      .clk(clk), .rst_n(rst_n), .digito(digito), .cambio_digito(cambio_digito),
      .enter_sync(enter_sync), .out_ready(out_ready), .out_valid(out_valid),
      .out_valor(out_valor), .out_cant(out_cant), .disp_valor(disp_valor),
      .disp_cant(disp_cant), .tecla_pulso(tecla_pulso), .overflow(overflow)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0;
   int n_puls = 0, n_ovf = 0;

   always @(posedge clk) begin
      if (tecla_pulso) n_puls <= n_puls + 1;
      if (overflow)    n_ovf  <= n_ovf + 1;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic sight(input logic [3:0] code);
      @(negedge clk);
      cambio_digito = 1'b1;
      digito = {1'b0, code};
   endtask

   task automatic quiet(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         cambio_digito = 1'b0;
         digito = 5'd16;
      end
   endtask

   task automatic press(input logic [3:0] code, input int hold);
      for (int i = 0; i < hold; i++) sight(code);
      quiet(10);
      @(negedge clk);
   endtask

   typedef struct {
      logic [3:0]  code;
      int          hold;
      logic [15:0] val;
      logic [2:0]  cant;
      int          puls;
      int          ovf;
   } vec_t;

   vec_t tv[$];

   initial begin
      int p0, o0;
      tv.push_back('{4'h1,   3, 16'h0001, 3'd1, 1, 0});
      tv.push_back('{4'h2,   3, 16'h0012, 3'd2, 1, 0});
      tv.push_back('{4'h3,   3, 16'h0123, 3'd3, 1, 0});
      tv.push_back('{4'hE,   3, 16'h0000, 3'd0, 1, 0});
      tv.push_back('{4'h5, 100, 16'h0005, 3'd1, 1, 0});
      tv.push_back('{4'h5,   3, 16'h0055, 3'd2, 1, 0});
      tv.push_back('{4'hA,   3, 16'h0055, 3'd2, 1, 0});
      tv.push_back('{4'hF,   3, 16'h0005, 3'd1, 1, 0});
      tv.push_back('{4'hF,   3, 16'h0000, 3'd0, 1, 0});
      tv.push_back('{4'hF,   3, 16'h0000, 3'd0, 1, 0});
      tv.push_back('{4'h9,   2, 16'h0000, 3'd0, 0, 0});
      tv.push_back('{4'h1,   3, 16'h0001, 3'd1, 1, 0});
      tv.push_back('{4'h2,   3, 16'h0012, 3'd2, 1, 0});
      tv.push_back('{4'h3,   3, 16'h0123, 3'd3, 1, 0});
      tv.push_back('{4'h4,   3, 16'h1234, 3'd4, 1, 0});
      tv.push_back('{4'h5,   3, 16'h1234, 3'd4, 1, 1});
      tv.push_back('{4'hF,   3, 16'h0123, 3'd3, 1, 0});
      tv.push_back('{4'hE,   3, 16'h0000, 3'd0, 1, 0});

      // Reset state
      #12;
      chk("rst out_valid", 32'(out_valid), 0);
      chk("rst out_valor", 32'(out_valor), 0);
      chk("rst out_cant", 32'(out_cant), 0);
      chk("rst disp_valor", 32'(disp_valor), 0);
      chk("rst disp_cant", 32'(disp_cant), 0);
      chk("rst pulses", 32'({tecla_pulso, overflow}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      quiet(2);

      foreach (tv[i]) begin
         p0 = n_puls;
         o0 = n_ovf;
         press(tv[i].code, tv[i].hold);
         chk($sformatf("vec%0d disp_valor", i), 32'(disp_valor), 32'(tv[i].val));
         chk($sformatf("vec%0d disp_cant", i), 32'(disp_cant), 32'(tv[i].cant));
         chk($sformatf("vec%0d tecla_pulso", i), 32'(n_puls - p0), 32'(tv[i].puls));
         chk($sformatf("vec%0d overflow", i), 32'(n_ovf - o0), 32'(tv[i].ovf));
      end

      // Bounce 5,8,5,5,5 -> single accept of 5
      p0 = n_puls;
      sight(4'h5); sight(4'h8); sight(4'h5); sight(4'h5); sight(4'h5);
      quiet(10);
      @(negedge clk);
      chk("bounce disp_valor", 32'(disp_valor), 32'h0005);
      chk("bounce disp_cant", 32'(disp_cant), 1);
      chk("bounce pulses", 32'(n_puls - p0), 1);
      press(4'hE, 3);

      // Commit with back-pressure
      press(4'h4, 3);
      press(4'h2, 3);
      enter_sync = 1'b1;
      out_ready = 1'b0;
      @(negedge clk);
      chk("commit out_valid", 32'(out_valid), 1);
      chk("commit out_valor", 32'(out_valor), 32'h0042);
      chk("commit out_cant", 32'(out_cant), 2);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("stall%0d out_valid", i), 32'(out_valid), 1);
         chk($sformatf("stall%0d out_valor", i), 32'(out_valor), 32'h0042);
         chk($sformatf("stall%0d out_cant", i), 32'(out_cant), 2);
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("hs out_valid", 32'(out_valid), 0);
      chk("hs disp_cant", 32'(disp_cant), 0);
      chk("hs disp_valor", 32'(disp_valor), 0);
      out_ready = 1'b0;
      enter_sync = 1'b0;
      quiet(3);
      enter_sync = 1'b1;
      quiet(2);
      chk("empty enter out_valid", 32'(out_valid), 0);
      enter_sync = 1'b0;
      quiet(10);

      // Enter coinciding with a key accept: enter wins
      press(4'h7, 3);
      p0 = n_puls;
      sight(4'h9); sight(4'h9); sight(4'h9);
      enter_sync = 1'b1;
      quiet(1);
      chk("coinc out_valid", 32'(out_valid), 1);
      chk("coinc out_valor", 32'(out_valor), 32'h0007);
      chk("coinc out_cant", 32'(out_cant), 1);
      out_ready = 1'b1;
      quiet(1);
      out_ready = 1'b0;
      enter_sync = 1'b0;
      quiet(10);
      chk("coinc pulses", 32'(n_puls - p0), 0);
      chk("coinc disp_cant", 32'(disp_cant), 0);
      chk("coinc out_valid after", 32'(out_valid), 0);

      // Async reset mid-COMMIT
      press(4'h3, 3);
      enter_sync = 1'b1;
      @(negedge clk);
      chk("pre-rst out_valid", 32'(out_valid), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async rst out_valid", 32'(out_valid), 0);
      chk("async rst out_valor", 32'(out_valor), 0);
      chk("async rst out_cant", 32'(out_cant), 0);
      chk("async rst disp_cant", 32'(disp_cant), 0);
      chk("async rst disp_valor", 32'(disp_valor), 0);
      @(negedge clk);
      rst_n = 1'b1;
      enter_sync = 1'b0;
      quiet(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/control_ingreso_teclado.md
Name: control_ingreso_teclado

Overview:
- Sequences the 4x4 keypad scan driver: consumes its per-cycle `digito` / `cambio_digito` / `enter_sync` outputs.
- Debounces and edge-detects key presses so each physical press produces exactly one action.
- Assembles up to NDIG BCD digits with backspace and clear editing.
- Hands the finished number to the consumer over a valid/ready handshake on enter. It sits between the keypad driver and the application logic / 7-segment display.

Parameters:
- NDIG, 4: maximum number of digits in the entry buffer (1..7).
- DEB_N, 3: number of sightings of the same code needed to accept a key.
- REL_N, 8: consecutive quiet cycles that count as a release (must be >= 4, one full column scan).
- TMO, 1000: inactivity timeout in clk cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock, same as the keypad driver (100 Hz).
- rst_n  in  1  asynchronous active-low reset.
- digito  in  5  key code from the driver: 0-15 valid key, 16 = none, 17 = invalid.
- cambio_digito  in  1  driver flag: a key is seen in the currently scanned column.
- enter_sync  in  1  synchronised enter button level.
- out_ready  in  1  consumer accepts the committed value.
- out_valid  out  1  committed value available.
- out_valor  out  4*NDIG  committed BCD value; the last digit typed is in nibble 0.
- out_cant  out  3  number of digits in out_valor.
- disp_valor  out  4*NDIG  live edit buffer, for the display.
- disp_cant  out  3  live digit count.
- tecla_pulso  out  1  one-cycle pulse on every accepted key.
- overflow  out  1  one-cycle pulse when a digit is typed into a full buffer.

Behaviour:
- Reset values: all outputs 0, buffer 0, count 0, FSM in IDLE, enter edge register 0. Reset is asynchronous at any point, including during COMMIT; out_valid drops immediately.
- Sighting: a cycle with cambio_digito=1 and digito<=15. A cycle with cambio_digito=0 or digito>=16 is quiet.
- Quiet counter: counts consecutive quiet cycles, saturates at REL_N, and clears on any sighting.
- FSM states:
  - IDLE: on a sighting, capture the candidate code, set the sighting count to 1, and go to DEBOUNCE.
  - DEBOUNCE:
    - Same-code sighting: count+1. When the count reaches DEB_N, accept the key (action below), pulse tecla_pulso, and go to HELD.
    - Different-code sighting: restart with the new candidate, count=1.
    - Quiet counter reaches REL_N: return to IDLE with no action.
  - HELD: ignore all sightings. Quiet counter reaches REL_N: go to IDLE. A held key never repeats.
  - COMMIT: out_valid=1 and keys are ignored. When out_valid&&out_ready, on the next cycle: out_valid=0, buffer and count cleared, go to HELD.
- Key actions, applied in the accept cycle so the registers update the next cycle:
  - Codes 0-9:
    - If count<NDIG: buffer <= {buffer[4*NDIG-5:0], code}, count+1.
    - Otherwise: buffer unchanged and overflow pulses.
  - Code 0xF (backspace): if count>0, buffer shifts right by 4 with the top nibble zeroed, count-1. Otherwise no-op.
  - Code 0xE (clear): buffer=0, count=0.
  - Codes 0xA-0xD: tecla_pulso pulses, no buffer change.
- Enter:
  - Rising edge = enter_sync=1 while it was 0 in the previous cycle.
  - Valid only in IDLE, DEBOUNCE or HELD with count>0. Then out_valor <= buffer, out_cant <= count, out_valid=1 next cycle, and go to COMMIT.
  - With count=0 the edge is ignored.
  - If the edge coincides with a key acceptance, enter wins: the key action is discarded, tecla_pulso does not fire, and after the handshake the FSM goes to HELD.
- Stability: out_valor and out_cant stay stable while out_valid=1 and !out_ready.
- Display: disp_valor / disp_cant always mirror the buffer/count registers.
- Latency: key accept occurs at most DEB_N*4 cycles after the first sighting. Commit asserts out_valid 1 cycle after the enter edge.

Optional Feature:
- CONTROL_INGRESO_TIMEOUT_EN defined:
  - A counter of cycles since the last accepted key or enter edge runs in IDLE and HELD while count>0.
  - When it reaches TMO, buffer and count clear; state is unchanged and no pulse is generated.
  - It does not run in COMMIT.
- Not defined: the counter logic is absent and the buffer persists indefinitely.

Test Plan:
- Press 1, 2, 3 (each: digito held for 3 scans, then 8 quiet cycles) -> tecla_pulso x3, disp_valor=0x0123, disp_cant=3.
- Bounce: sightings 5, 8, 5, 5, 5 -> a single accept of 5 only; one tecla_pulso.
- Key held 100 cycles -> exactly one digit added; a re-press after 8 quiet cycles adds a second digit.
- Type 1,2,3,4,5 with NDIG=4 -> 5 dropped, overflow pulse, disp_valor=0x1234. Then F -> 0x0123, cnt=3. Then E -> 0, cnt=0.
- Type 4,2, enter edge with out_ready=0 for 5 cycles -> out_valid held with out_valor=0x0042 and out_cant=2 stable. Raise out_ready -> out_valid falls next cycle, disp_cant=0. Enter with empty buffer -> no out_valid.
- rst_n low mid-COMMIT -> out_valid=0 asynchronously, all outputs 0. With CONTROL_INGRESO_TIMEOUT_EN and TMO=1000: digit 7 then 1000 idle cycles -> disp_cant=0.
